button_press_counter: RTL

//  Input-side companion to the LED oscillator counter. Samples a raw, bouncy, active-low

---
 rtl/button_press_counter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/button_press_counter.sv
// Synchronises, debounces and counts presses of an active-low push-button.
// Emits one-cycle press / long-press strobes; a long hold clears the LED count.
module button_press_counter #(
    parameter int DEBOUNCE_CYCLES   = 120000,
    parameter int LONG_PRESS_CYCLES = 12000000,
    parameter int COUNT_W           = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_in,
    output logic [COUNT_W-1:0] led,
    output logic               btn_state,
    output logic               press_pulse,
    output logic               long_press_pulse
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);
    localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_t;

    logic [1:0]         sync_q;
    logic               raw_pressed;
    logic [DB_W-1:0]    db_cnt;
    logic               mismatch;
    logic               db_done;
    logic               btn_rise;
    logic               btn_fall;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [HOLD_W-1:0]  hold_nxt;
    logic               hold_done;
    state_t             state;
    state_t             state_nxt;
    logic               press_nxt;
    logic               long_nxt;
    logic [COUNT_W-1:0] led_nxt;

    // Synchroniser resets to the released level so a held button reads as a new press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], btn_in};
        end
    end

    assign raw_pressed = ~sync_q[1];
    assign mismatch    = raw_pressed ^ btn_state;
    assign db_done     = mismatch && (db_cnt == DB_MAX);
    assign btn_rise    = db_done && !btn_state;
    assign btn_fall    = db_done && btn_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt    <= '0;
            btn_state <= 1'b0;
        end else begin
            if (!mismatch || db_done) begin
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
            btn_state <= btn_state ^ db_done;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign hold_done = (state == PRESSED) && (hold_cnt == HOLD_MAX);

    // Release wins over a long press landing on the same edge.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (btn_rise) state_nxt = PRESSED;
            PRESSED: begin
                if (btn_fall)       state_nxt = IDLE;
                else if (hold_done) state_nxt = HELD;
            end
            HELD:    if (btn_fall) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        press_nxt = (state == IDLE) && btn_rise;
        long_nxt  = (state == PRESSED) && (state_nxt == HELD);
        hold_nxt  = '0;
        if (state == PRESSED && state_nxt == PRESSED) begin
            hold_nxt = hold_cnt + HOLD_W'(1);
        end else if (state_nxt == HELD) begin
            hold_nxt = hold_cnt;
        end
        led_nxt = led;
        if (press_nxt) begin
            led_nxt = led + COUNT_W'(1);
        end else if (long_nxt) begin
            led_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt         <= '0;
            led              <= '0;
            press_pulse      <= 1'b0;
            long_press_pulse <= 1'b0;
        end else begin
            hold_cnt         <= hold_nxt;
            led              <= led_nxt;
            press_pulse      <= press_nxt;
            long_press_pulse <= long_nxt;
        end
    end

endmodule
